// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_pkg
// Brief    : FunSel encodings and the per-register next-value function for
//            general_register_file. GRF_SATURATE_EN makes inc/dec saturate.
// Revision : 1.0
// ============================================================================
package grf_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_LOZX = 3'b100;
    localparam logic [2:0] FS_LOWR = 3'b101;
    localparam logic [2:0] FS_HIWR = 3'b110;
    localparam logic [2:0] FS_SEXT = 3'b111;

    // Working width of the shared function; register WIDTH must stay below it.
    localparam int GRF_MAX_W = 64;

    typedef struct packed {
        logic [GRF_MAX_W-1:0] value;
        logic                 wrap_set;
        logic                 wrap_clr;
    } grf_next_t;

    function automatic grf_next_t grf_next(
        input logic [2:0]           fs,
        input logic [GRF_MAX_W-1:0] r,
        input logic [GRF_MAX_W-1:0] i,
        input int                   width
    );
        logic [GRF_MAX_W-1:0] mask;
        logic [GRF_MAX_W-1:0] lo_mask;
        logic [GRF_MAX_W-1:0] lo;
        logic                 sign;
        int                   half;
        grf_next_t            res;

        half    = width / 2;
        mask    = {GRF_MAX_W{1'b1}} >> (GRF_MAX_W - width);
        lo_mask = {GRF_MAX_W{1'b1}} >> (GRF_MAX_W - half);
        lo      = i & lo_mask;
        // Top bit of the low half, isolated without a variable bit-select.
        sign    = |(i & (lo_mask ^ (lo_mask >> 1)));

        res.value    = r & mask;
        res.wrap_set = 1'b0;
        res.wrap_clr = 1'b0;

        case (fs)
            FS_DEC: begin
                res.wrap_set = ((r & mask) == '0);
                res.value    = (r - GRF_MAX_W'(1)) & mask;
            end
            FS_INC: begin
                res.wrap_set = ((r & mask) == mask);
                res.value    = (r + GRF_MAX_W'(1)) & mask;
            end
            FS_LOAD: begin
                res.value    = i & mask;
                res.wrap_clr = 1'b1;
            end
            FS_CLR: begin
                res.value    = '0;
                res.wrap_clr = 1'b1;
            end
            FS_LOZX: res.value = lo;
            FS_LOWR: res.value = (r & mask & ~lo_mask) | lo;
            FS_HIWR: res.value = ((lo << half) | (r & lo_mask)) & mask;
            FS_SEXT: res.value = sign ? ((mask & ~lo_mask) | lo) : lo;
            default: res.value = r & mask;
        endcase

`ifdef GRF_SATURATE_EN
        if (res.wrap_set) begin
            res.value = r & mask;
        end
`endif
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/general_register_file_cell.sv
`default_nettype none
// ============================================================================
// Module   : grf_cell
// Brief    : One WIDTH-bit register with its sticky wrap flag.
// Revision : 1.0
// ============================================================================
module grf_cell
    import grf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);

    logic [WIDTH-1:0]           r_q;
    logic                       r_wrap;
    logic [GRF_MAX_W-1:0]       w_r_ext;
    logic [GRF_MAX_W-1:0]       w_i_ext;
    grf_next_t                  w_nxt;
    logic [GRF_MAX_W-WIDTH-1:0] w_unused_hi;

    always_comb begin
        w_r_ext              = '0;
        w_r_ext[WIDTH-1:0]   = r_q;
        w_i_ext              = '0;
        w_i_ext[WIDTH-1:0]   = I;
        w_nxt                = grf_next(FunSel, w_r_ext, w_i_ext, WIDTH);
    end

    // The function masks its result, so these bits are always zero.
    assign w_unused_hi = w_nxt.value[GRF_MAX_W-1:WIDTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (En) begin
            r_q <= w_nxt.value[WIDTH-1:0];
            if (w_nxt.wrap_set) begin
                r_wrap <= 1'b1;
            end else if (w_nxt.wrap_clr) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/general_register_file.sv
`default_nettype none
// ============================================================================
// Module   : general_register_file
// Brief    : NUM_REGS x WIDTH register file, shared FunSel update, two
//            combinational read ports, sticky wrap flags (GRF_SATURATE_EN).
// Revision : 1.0
// ============================================================================
module general_register_file
    import grf_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int NUM_REGS = 4,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [2:0]          FunSel,
    input  logic [WIDTH-1:0]    I,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] Wrap
);

    logic [WIDTH-1:0] w_q [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        grf_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .En     (RegSel[k]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (w_q[k]),
            .Wrap   (Wrap[k])
        );
    end

    // Out-of-range selects (non power-of-two NUM_REGS) read as zero.
    always_comb begin
        OutA = '0;
        if (int'(OutASel) < NUM_REGS) begin
            OutA = w_q[OutASel];
        end
    end

    always_comb begin
        OutB = '0;
        if (int'(OutBSel) < NUM_REGS) begin
            OutB = w_q[OutBSel];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_general_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_general_register_file
// Brief    : Directed self-checking bench for general_register_file.
// Revision : 1.0
// ============================================================================
module tb_general_register_file;

    localparam logic [2:0] F_DEC  = 3'b000;
    localparam logic [2:0] F_INC  = 3'b001;
    localparam logic [2:0] F_LOAD = 3'b010;
    localparam logic [2:0] F_CLR  = 3'b011;
    localparam logic [2:0] F_LOZX = 3'b100;
    localparam logic [2:0] F_LOWR = 3'b101;
    localparam logic [2:0] F_HIWR = 3'b110;
    localparam logic [2:0] F_SEXT = 3'b111;

`ifdef GRF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic [2:0]  FunSel;
    logic [15:0] I;
    logic [3:0]  RegSel;
    logic [1:0]  OutASel;
    logic [1:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;
    logic [3:0]  Wrap;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    int         m_r [4] = '{default: 0};
    logic [3:0] m_wrap  = 4'b0000;

    general_register_file #(
        .WIDTH    (16),
        .NUM_REGS (4)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .FunSel  (FunSel),
        .I       (I),
        .RegSel  (RegSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB),
        .Wrap    (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on register values 0..65535.
    task automatic model_apply(input int k);
        int v;
        int lo;
        v  = m_r[k];
        lo = int'(I) % 256;
        case (FunSel)
            F_DEC: begin
                if (v == 0) begin
                    m_wrap[k] = 1'b1;
                    v = SAT ? 0 : 65535;
                end else v = v - 1;
            end
            F_INC: begin
                if (v == 65535) begin
                    m_wrap[k] = 1'b1;
                    v = SAT ? 65535 : 0;
                end else v = v + 1;
            end
            F_LOAD: begin v = int'(I); m_wrap[k] = 1'b0; end
            F_CLR:  begin v = 0;       m_wrap[k] = 1'b0; end
            F_LOZX: v = lo;
            F_LOWR: v = (v / 256) * 256 + lo;
            F_HIWR: v = lo * 256 + (v % 256);
            default: v = (lo >= 128) ? 65280 + lo : lo;
        endcase
        m_r[k] = v;
    endtask

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < 4; k++) m_r[k] = 0;
            m_wrap = 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) if (RegSel[k]) model_apply(k);
        end
    end

    always @(negedge Clock) begin
        if (chk_on && Reset) begin
            check("cmp_outa", OutA, 16'(m_r[OutASel]));
            check("cmp_outb", OutB, 16'(m_r[OutBSel]));
            check("cmp_wrap", {12'h000, Wrap}, {12'h000, m_wrap});
        end
    end

    task automatic op(input logic [3:0] rs, input logic [2:0] fs, input logic [15:0] d);
        @(negedge Clock);
        #1;
        RegSel = rs;
        FunSel = fs;
        I      = d;
        @(posedge Clock);
        #1;
        RegSel = 4'b0000;
    endtask

    task automatic peek(input logic [1:0] a, input logic [1:0] b);
        OutASel = a;
        OutBSel = b;
        #1;
    endtask

    initial begin
        Reset = 1'b0; FunSel = F_DEC; I = '0; RegSel = '0; OutASel = '0; OutBSel = '0;
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b1;
        chk_on = 1'b1;
        peek(0, 3);
        check("reset_r0", OutA, 16'h0000);
        check("reset_wrap", {12'h000, Wrap}, 16'h0000);

        // Asynchronous reset mid-cycle clears value and flag at once.
        op(4'b0010, F_LOAD, 16'h1234);
        op(4'b0001, F_DEC, 16'h0000);
        peek(1, 0);
        check("r1_load", OutA, 16'h1234);
        check("wrap_pre_rst", {12'h000, Wrap}, 16'h0001);
        @(negedge Clock);
        #3 Reset = 1'b0;
        #1;
        check("async_rst_outa", OutA, 16'h0000);
        check("async_rst_wrap", {12'h000, Wrap}, 16'h0000);
        @(negedge Clock);
        #1 Reset = 1'b1;

        // Multi-register write.
        op(4'b0101, F_LOAD, 16'hBEEF);
        peek(0, 2);
        check("multi_r0", OutA, 16'hBEEF);
        check("multi_r2", OutB, 16'hBEEF);
        peek(1, 3);
        check("multi_r1", OutA, 16'h0000);
        check("multi_r3", OutB, 16'h0000);

        // Half-word operations on R3.
        op(4'b1000, F_LOAD, 16'hAABB);
        op(4'b1000, F_LOWR, 16'h1280);
        peek(3, 3);
        check("lowr", OutA, 16'hAA80);
        op(4'b1000, F_HIWR, 16'h1280);
        check("hiwr", OutA, 16'h8080);
        op(4'b1000, F_SEXT, 16'h0080);
        check("sext", OutA, 16'hFF80);
        op(4'b1000, F_LOZX, 16'h0080);
        check("lozx", OutA, 16'h0080);

        // Wrap / saturate behaviour.
        op(4'b0001, F_LOAD, 16'hFFFF);
        op(4'b0001, F_INC, 16'h0000);
        peek(0, 0);
        check("inc_wrap_val", OutA, SAT ? 16'hFFFF : 16'h0000);
        check("inc_wrap_flag", {12'h000, Wrap}, 16'h0001);
        op(4'b0001, F_INC, 16'h0000);
        check("inc_sticky_val", OutA, SAT ? 16'hFFFF : 16'h0001);
        check("inc_sticky_flag", {12'h000, Wrap}, 16'h0001);
        op(4'b0001, F_CLR, 16'h0000);
        check("clr_flag", {12'h000, Wrap}, 16'h0000);
        op(4'b0010, F_CLR, 16'h0000);
        op(4'b0010, F_DEC, 16'h0000);
        peek(1, 1);
        check("dec_wrap_val", OutA, SAT ? 16'h0000 : 16'hFFFF);
        check("dec_wrap_flag", {12'h000, Wrap}, 16'h0010 >> 3);

        // All registers at once, each from its own value.
        op(4'b1111, F_INC, 16'h0000);
        peek(2, 3);
        check("all_r2", OutA, 16'hBEF0);
        check("all_r3", OutB, 16'h0081);
        check("all_wrap", {12'h000, Wrap}, 16'h0002);

        // Read port shows the old value until the write edge.
        @(negedge Clock);
        #1;
        OutASel = 2; OutBSel = 2;
        RegSel = 4'b0100; FunSel = F_LOAD; I = 16'h5555;
        #1;
        check("read_before_edge", OutA, 16'hBEF0);
        @(posedge Clock);
        #1;
        RegSel = 4'b0000;
        check("read_after_edge", OutA, 16'h5555);

        // Empty RegSel is a no-op for every function.
        for (int f = 0; f < 8; f++) op(4'b0000, 3'(f), 16'hA5A5);
        peek(2, 3);
        check("noop_r2", OutA, 16'h5555);
        check("noop_r3", OutB, 16'h0081);
        check("noop_wrap", {12'h000, Wrap}, 16'h0002);

        repeat (2) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/general_register_file.md
Name: general_register_file

Overview:
- Parametrised, multi-register successor to the single 16-bit FunSel register.
- Holds NUM_REGS registers of WIDTH bits. Any subset can be updated in one cycle with a shared 8-function operation code.
- Two combinational read ports feed the ALU/address muxes of the datapath.
- Adds sticky per-register wrap flags so the control unit can detect counter overflow/underflow.

Parameters:
- WIDTH, 16, register width in bits; must be even and >= 4; H = WIDTH/2 is the half-word width.
- NUM_REGS, 4, number of registers; 2..16.
- SEL_W, $clog2(NUM_REGS), read-select width; derived, not to be overridden.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- FunSel  input  3  operation code applied to every enabled register.
- I  input  WIDTH  write data.
- RegSel  input  NUM_REGS  one-hot-or-multi enable mask; bit k enables R[k].
- OutASel  input  SEL_W  read port A select.
- OutBSel  input  SEL_W  read port B select.
- OutA  output  WIDTH  R[OutASel].
- OutB  output  WIDTH  R[OutBSel].
- Wrap  output  NUM_REGS  sticky wrap flag per register.

Behaviour:
- Reset (Reset=0, asynchronous): all R[k]=0 and Wrap=0 immediately. This holds regardless of Clock, and an operation in flight is discarded. Release is synchronised by the user; the block has no requirement on release timing.
- On each rising Clock edge, for every k with RegSel[k]=1, R[k] is updated per FunSel. Registers with RegSel[k]=0 hold value and flag.
- FunSel encoding (L = I[H-1:0]):
  - 000: R-1, modulo 2^WIDTH.
  - 001: R+1, modulo 2^WIDTH.
  - 010: load I.
  - 011: clear to 0.
  - 100: zero-extend L.
  - 101: keep R high half, write L into low half.
  - 110: {L, R low half}.
  - 111: sign-extend L using I[H-1].
- Wrap[k]:
  - Set when 001 is applied with R[k] all-ones, or 000 is applied with R[k]=0.
  - Cleared by 010 or 011 on that register.
  - Unchanged by 100-111 and by non-wrapping inc/dec.
  - If set and cleared in the same cycle is impossible by encoding.
- Read ports are purely combinational. A write on edge n is visible on OutA/OutB after edge n; there is no write-through bypass.
- Both ports may select the same register.
- If NUM_REGS is not a power of two, a select >= NUM_REGS returns 0.
- RegSel=0 is a legal no-op.
- All-ones RegSel updates every register identically from its own current value.
- Every register is clocked every cycle; no latch inference.
- Outputs never show X after reset.

Optional Feature:
- Macro GRF_SATURATE_EN.
- When defined: 001 on all-ones and 000 on zero saturate, so the register keeps its value. Wrap[k] is still set and acts as a saturation flag.
- When undefined: modular wrap as specified above.
- All other functions are identical in both builds.

Decomposition:
- Package grf_pkg holds:
  - the FunSel localparams (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LOZX, FS_LOWR, FS_HIWR, FS_SEXT);
  - a function computing the next value and wrap event from (FunSel, R, I).
- One natural sub-module: grf_cell, one WIDTH-bit register plus its wrap flag. It is instantiated NUM_REGS times by a generate loop.
- The top level holds only the cells and two read muxes.

Test Plan (WIDTH=16, NUM_REGS=4):
1. Reset: assert Reset=0 mid-cycle after loading R1=0x1234 -> OutA (sel 1)=0x0000 and Wrap=0000 immediately, without waiting for a clock edge.
2. Multi-write: RegSel=0101, FunSel=010, I=0xBEEF, one edge -> R0=R2=0xBEEF, R1=R3 unchanged. OutA sel0=0xBEEF and OutB sel2=0xBEEF on the following cycle.
3. Half ops, with R3=0xAABB and I=0x1280:
   - 101 -> R3=0xAA80;
   - then 110 -> R3=0x8080;
   - 111 with I=0x0080 -> 0xFF80;
   - 100 -> 0x0080.
4. Wrap:
   - R0=0xFFFF, 001 -> R0=0x0000, Wrap[0]=1; another 001 -> R0=0x0001, Wrap[0] stays 1; 011 -> Wrap[0]=0.
   - R1=0, 000 -> 0xFFFF, Wrap[1]=1.
5. Saturate build (GRF_SATURATE_EN): R0=0xFFFF, 001 -> R0=0xFFFF, Wrap[0]=1. R0=0, 000 -> R0=0x0000.
6. Read timing: load I=0x5555 into R2 while OutASel=2 -> OutA shows the old value until the edge and 0x5555 after it. RegSel=0000 with any FunSel -> no register or flag change.
